// File: rtl/id_fwd_hazard_unit.sv
// ID-stage operand forwarding (MEM > WB > RF) and load-use / branch hazard stall FSM.
// Optional macro HAZARD_PERF_EN adds a saturating stall-cycle counter output.
module id_fwd_hazard_unit #(
    parameter int NUM_RD_PORTS = 2,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int LOAD_LAT     = 1
) (
`ifdef HAZARD_PERF_EN
    output logic [31:0]                    stall_cycles_o,
`endif
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [NUM_RD_PORTS-1:0]        rd_en_i,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0] raddr_i,
    input  logic [NUM_RD_PORTS*DATA_W-1:0] rf_rdata_i,
    input  logic                           ex_we_i,
    input  logic [ADDR_W-1:0]              ex_waddr_i,
    input  logic                           ex_is_load_i,
    input  logic                           mem_we_i,
    input  logic [ADDR_W-1:0]              mem_waddr_i,
    input  logic [DATA_W-1:0]              mem_wdata_i,
    input  logic                           wb_we_i,
    input  logic [ADDR_W-1:0]              wb_waddr_i,
    input  logic [DATA_W-1:0]              wb_wdata_i,
    input  logic                           branch_flag_i,
    input  logic                           flush_i,
    output logic [NUM_RD_PORTS*DATA_W-1:0] rdata_o,
    output logic                           stall_o,
    output logic                           bubble_o
);

    localparam int CW = $clog2(LOAD_LAT + 2);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   haz_n;
    logic            hazard;
    logic            any_hit_ex;
    logic            stall_raw;

    logic [NUM_RD_PORTS-1:0] hit_ex;
    logic [NUM_RD_PORTS-1:0] hit_mem;
    logic [NUM_RD_PORTS-1:0] hit_wb;

    // Register 0 is hard-wired: it never matches a producer, so it never forwards or stalls.
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic              nz;
        assign addr       = raddr_i[p*ADDR_W +: ADDR_W];
        assign nz         = (addr != '0);
        assign hit_ex[p]  = ex_we_i  && (ex_waddr_i  == addr) && nz;
        assign hit_mem[p] = mem_we_i && (mem_waddr_i == addr) && nz;
        assign hit_wb[p]  = wb_we_i  && (wb_waddr_i  == addr) && nz;
        assign rdata_o[p*DATA_W +: DATA_W] = !rst_n_i   ? '0          :
                                             hit_mem[p] ? mem_wdata_i :
                                             hit_wb[p]  ? wb_wdata_i  :
                                                          rf_rdata_i[p*DATA_W +: DATA_W];
    end

    assign any_hit_ex = |(hit_ex & rd_en_i);

    always_comb begin
        haz_n = '0;
        if (any_hit_ex) begin
            if (branch_flag_i) begin
                haz_n = ex_is_load_i ? CW'(LOAD_LAT + 1) : CW'(1);
            end else if (ex_is_load_i) begin
                haz_n = CW'(LOAD_LAT);
            end
        end
    end

    assign hazard = (haz_n != '0);

    // The detection cycle is the first stall cycle, so STALL only covers the remaining N-1.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        if (flush_i) begin
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard) begin
                        stall_raw = 1'b1;
                        if (haz_n > CW'(1)) begin
                            state_d = STALL;
                            cnt_d   = haz_n - CW'(1);
                        end
                    end
                end
                STALL: begin
                    stall_raw = 1'b1;
                    cnt_d     = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_o  = stall_raw && rst_n_i;
    assign bubble_o = stall_raw && rst_n_i;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
        end else if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_fwd_hazard_unit.sv
// Directed self-checking bench: three instances (LOAD_LAT = 1, 2, 3) share one stimulus stream
// so each stall-length rule is checked for several latencies at once.
module tb_id_fwd_hazard_unit;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [1:0]  rdEn;
    logic [9:0]  raddr;
    logic [63:0] rfRdata;
    logic        exWe;
    logic [4:0]  exWaddr;
    logic        exIsLoad;
    logic        memWe;
    logic [4:0]  memWaddr;
    logic [31:0] memWdata;
    logic        wbWe;
    logic [4:0]  wbWaddr;
    logic [31:0] wbWdata;
    logic        branchFlag;
    logic        flush;

    logic [63:0] rdata1, rdata2, rdata3;
    logic        stall1, stall2, stall3;
    logic        bubble1, bubble2, bubble3;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf1, perf2, perf3;
`endif

    int testsRun  = 0;
    int failCount = 0;

    always #5 clock = ~clock;

    id_fwd_hazard_unit #(.NUM_RD_PORTS(2), .DATA_W(32), .ADDR_W(5), .LOAD_LAT(1)) u_lat1 (
`ifdef HAZARD_PERF_EN
        .stall_cycles_o(perf1),
`endif
        .clk_i(clock), .rst_n_i(rst_n), .rd_en_i(rdEn), .raddr_i(raddr), .rf_rdata_i(rfRdata),
        .ex_we_i(exWe), .ex_waddr_i(exWaddr), .ex_is_load_i(exIsLoad),
        .mem_we_i(memWe), .mem_waddr_i(memWaddr), .mem_wdata_i(memWdata),
        .wb_we_i(wbWe), .wb_waddr_i(wbWaddr), .wb_wdata_i(wbWdata),
        .branch_flag_i(branchFlag), .flush_i(flush),
        .rdata_o(rdata1), .stall_o(stall1), .bubble_o(bubble1)
    );

    id_fwd_hazard_unit #(.NUM_RD_PORTS(2), .DATA_W(32), .ADDR_W(5), .LOAD_LAT(2)) u_lat2 (
`ifdef HAZARD_PERF_EN
        .stall_cycles_o(perf2),
`endif
        .clk_i(clock), .rst_n_i(rst_n), .rd_en_i(rdEn), .raddr_i(raddr), .rf_rdata_i(rfRdata),
        .ex_we_i(exWe), .ex_waddr_i(exWaddr), .ex_is_load_i(exIsLoad),
        .mem_we_i(memWe), .mem_waddr_i(memWaddr), .mem_wdata_i(memWdata),
        .wb_we_i(wbWe), .wb_waddr_i(wbWaddr), .wb_wdata_i(wbWdata),
        .branch_flag_i(branchFlag), .flush_i(flush),
        .rdata_o(rdata2), .stall_o(stall2), .bubble_o(bubble2)
    );

    id_fwd_hazard_unit #(.NUM_RD_PORTS(2), .DATA_W(32), .ADDR_W(5), .LOAD_LAT(3)) u_lat3 (
`ifdef HAZARD_PERF_EN
        .stall_cycles_o(perf3),
`endif
        .clk_i(clock), .rst_n_i(rst_n), .rd_en_i(rdEn), .raddr_i(raddr), .rf_rdata_i(rfRdata),
        .ex_we_i(exWe), .ex_waddr_i(exWaddr), .ex_is_load_i(exIsLoad),
        .mem_we_i(memWe), .mem_waddr_i(memWaddr), .mem_wdata_i(memWdata),
        .wb_we_i(wbWe), .wb_waddr_i(wbWaddr), .wb_wdata_i(wbWdata),
        .branch_flag_i(branchFlag), .flush_i(flush),
        .rdata_o(rdata3), .stall_o(stall3), .bubble_o(bubble3)
    );

    task automatic nextCycle;
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] waddr, input logic isLoad,
                                 input logic br, input logic fl);
        exWe       = we;
        exWaddr    = waddr;
        exIsLoad   = isLoad;
        branchFlag = br;
        flush      = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rdEn     = 2'b01;
        raddr    = {5'd0, 5'd5};
        rfRdata  = {32'h1111_2222, 32'h3333_4444};
        memWe    = 1'b0; memWaddr = '0; memWdata = '0;
        wbWe     = 1'b0; wbWaddr  = '0; wbWdata  = '0;
        applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        #2;
        checkOutput("rst_rdata0", rdata1[31:0], 32'h0);
        checkOutput("rst_rdata1", rdata1[63:32], 32'h0);
        checkOutput("rst_stall", 32'(stall3), 32'd0);
        checkOutput("rst_bubble", 32'(bubble3), 32'd0);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        nextCycle;
        nextCycle;
        rst_n = 1'b1;
        #1;

        // forwarding priority
        memWe = 1'b1; memWaddr = 5'd5; memWdata = 32'h0000_000A;
        wbWe  = 1'b1; wbWaddr  = 5'd5; wbWdata  = 32'h0000_000B;
        #1 checkOutput("fwd_mem", rdata1[31:0], 32'h0000_000A);
        memWe = 1'b0;
        #1 checkOutput("fwd_wb", rdata1[31:0], 32'h0000_000B);
        wbWe = 1'b0;
        #1 checkOutput("fwd_rf", rdata1[31:0], 32'h3333_4444);

        // register 0 never forwards or stalls
        raddr = {5'd0, 5'd7};
        rdEn  = 2'b11;
        memWe = 1'b1; memWaddr = 5'd0;
        wbWe  = 1'b1; wbWaddr  = 5'd0;
        applyStimulus(1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("zero_rdata1", rdata1[63:32], 32'h1111_2222);
        checkOutput("zero_rdata0", rdata1[31:0], 32'h3333_4444);
        checkOutput("zero_stall1", 32'(stall1), 32'd0);
        checkOutput("zero_stall3", 32'(stall3), 32'd0);
        memWe = 1'b0; wbWe = 1'b0;
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        nextCycle;

        // load-use: lengths 1, 2, 3
        raddr = {5'd0, 5'd3};
        rdEn  = 2'b01;
        applyStimulus(1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("lu_c1_stall1", 32'(stall1), 32'd1);
        checkOutput("lu_c1_bubble1", 32'(bubble1), 32'd1);
        checkOutput("lu_c1_stall2", 32'(stall2), 32'd1);
        checkOutput("lu_c1_stall3", 32'(stall3), 32'd1);
        nextCycle;
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        memWe = 1'b1; memWaddr = 5'd3; memWdata = 32'hCAFE_0003;
        #1;
        checkOutput("lu_c2_stall1", 32'(stall1), 32'd0);
        checkOutput("lu_c2_rdata0", rdata1[31:0], 32'hCAFE_0003);
        checkOutput("lu_c2_stall2", 32'(stall2), 32'd1);
        checkOutput("lu_c2_stall3", 32'(stall3), 32'd1);
        nextCycle;
        memWe = 1'b0;
        #1;
        checkOutput("lu_c3_stall2", 32'(stall2), 32'd0);
        checkOutput("lu_c3_stall3", 32'(stall3), 32'd1);
        nextCycle;
        #1 checkOutput("lu_c4_stall3", 32'(stall3), 32'd0);
        nextCycle;

        // branch on load result through port 1, rd_en masks port 0
        raddr = {5'd9, 5'd0};
        rdEn  = 2'b10;
        applyStimulus(1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            #1;
            checkOutput($sformatf("brld_c%0d_stall1", c), 32'(stall1), 32'(c <= 2));
            checkOutput($sformatf("brld_c%0d_stall2", c), 32'(stall2), 32'(c <= 3));
            checkOutput($sformatf("brld_c%0d_stall3", c), 32'(stall3), 32'(c <= 4));
            nextCycle;
            if (c == 1) applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        end

        // branch on ALU result: single cycle
        applyStimulus(1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("bralu_c1_stall1", 32'(stall1), 32'd1);
        checkOutput("bralu_c1_stall3", 32'(stall3), 32'd1);
        nextCycle;
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("bralu_c2_stall2", 32'(stall2), 32'd0);
        checkOutput("bralu_c2_stall3", 32'(stall3), 32'd0);
        nextCycle;

        // masked port: EX hit on port 1 with rd_en only on port 0
        rdEn = 2'b01;
        applyStimulus(1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("mask_stall3", 32'(stall3), 32'd0);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        nextCycle;

        // flush in the second stall cycle
        raddr = {5'd0, 5'd3};
        applyStimulus(1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("fl_c1_stall3", 32'(stall3), 32'd1);
        nextCycle;
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("fl_c2_stall3", 32'(stall3), 32'd0);
        checkOutput("fl_c2_bubble3", 32'(bubble3), 32'd0);
        checkOutput("fl_c2_stall2", 32'(stall2), 32'd0);
        nextCycle;
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 checkOutput("fl_c3_stall3", 32'(stall3), 32'd0);
        nextCycle;

        // asynchronous reset in the middle of a stall
        applyStimulus(1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("ar_c1_stall3", 32'(stall3), 32'd1);
        nextCycle;
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 checkOutput("ar_c2_stall3", 32'(stall3), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("ar_stall3", 32'(stall3), 32'd0);
        checkOutput("ar_bubble3", 32'(bubble3), 32'd0);
        checkOutput("ar_rdata0", rdata3[31:0], 32'h0);
        #2 rst_n = 1'b1;
        nextCycle;
        #1;
        checkOutput("ar_c3_stall3", 32'(stall3), 32'd0);
        checkOutput("ar_c3_rdata0", rdata3[31:0], 32'h3333_4444);

`ifdef HAZARD_PERF_EN
        checkOutput("perf_rst", perf2, 32'd0);
        for (int e = 0; e < 2; e++) begin
            applyStimulus(1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
            nextCycle;
            applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            repeat (4) nextCycle;
        end
        applyStimulus(1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
        nextCycle;
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        nextCycle;
        checkOutput("perf_lat2", perf2, 32'd5);
        checkOutput("perf_lat1", perf1, 32'd3);
        checkOutput("perf_lat3", perf3, 32'd7);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/id_fwd_hazard_unit.md
Name: id_fwd_hazard_unit

Overview:
Parametrised ID-stage operand-forwarding and hazard unit for the in-order 5-stage pipeline.
- Serves NUM_RD_PORTS register-file read ports.
- Selects the MEM, WB or register-file value for each port.
- Detects load-use and branch-on-EX-result hazards and holds ID for a counted number of cycles via an internal stall FSM.
- Sits between the register file / ID decoder and the IF/ID and ID/EX pipeline-register control.

Parameters:
NUM_RD_PORTS, 2, number of operand read ports (1..4)
DATA_W, 32, register data width
ADDR_W, 5, register address width
LOAD_LAT, 1, stall cycles needed after a load in EX before MEM/WB can supply its data (1..7)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
rd_en_i  in  NUM_RD_PORTS  port p actually consumes its operand
raddr_i  in  NUM_RD_PORTS*ADDR_W  read address, port p at [p*ADDR_W +: ADDR_W]
rf_rdata_i  in  NUM_RD_PORTS*DATA_W  register-file read data per port
ex_we_i  in  1  EX instruction writes a register
ex_waddr_i  in  ADDR_W  EX destination
ex_is_load_i  in  1  EX instruction is a load
mem_we_i / mem_waddr_i / mem_wdata_i  in  1/ADDR_W/DATA_W  MEM write-back candidate
wb_we_i / wb_waddr_i / wb_wdata_i  in  1/ADDR_W/DATA_W  WB write-back candidate
branch_flag_i  in  1  ID instruction is a branch/jump that reads operands in ID
flush_i  in  1  pipeline flush (taken branch / exception)
rdata_o  out  NUM_RD_PORTS*DATA_W  resolved operands
stall_o  out  1  hold PC and IF/ID
bubble_o  out  1  insert NOP into ID/EX

Behaviour:
- Reset: rst_n_i is asynchronous and active-low. While low:
  - state=RUN, cnt=0, stall_o=0, bubble_o=0.
  - rdata_o=0 on all ports (combinational gate).
- Hit terms per port p: hit_X[p] = X_we & (X_waddr==raddr[p]) & (raddr[p]!=0), for X in {ex, mem, wb}. Address 0 never hits, never stalls, and always returns rf_rdata.
- Forwarding (combinational, zero latency), priority MEM > WB > RF. No EX->ID data path; ALU-to-ALU EX dependencies are resolved by the EX-stage bypass.
- Hazard N (stall length) in RUN, evaluated over ports with rd_en_i[p]=1:
  - branch_flag_i & any hit_ex & ex_is_load_i -> N=LOAD_LAT+1.
  - branch_flag_i & any hit_ex & !ex_is_load_i -> N=1.
  - !branch_flag_i & any hit_ex & ex_is_load_i -> N=LOAD_LAT.
  - otherwise no hazard.
- FSM:
  - RUN: if hazard, stall_o=bubble_o=1 in the detection cycle (this counts as cycle 1 of N). If N>1, go to STALL with cnt=N-1. If N==1, stay in RUN.
  - STALL: stall_o=bubble_o=1; cnt decrements each cycle; when cnt==1, next state is RUN. New hazards are not evaluated in STALL.
- flush_i has priority over everything: stall_o=bubble_o=0 the same cycle; next state RUN, cnt=0.
- Multiple ports hitting in the same cycle produce a single stall of the largest N.
- rd_en_i[p]=0 masks hazard detection for port p but not forwarding.
- cnt width = $clog2(LOAD_LAT+2).

Optional Feature:
HAZARD_PERF_EN:
- Defined:
  - Adds output stall_cycles_o [31:0], which increments on every clock where stall_o=1.
  - It saturates at 32'hFFFF_FFFF and resets to 0.
- Undefined: port absent; no counter logic.

Test Plan:
- Forward priority: raddr0=5, mem_we=1/mem_waddr=5/mem_wdata=32'hA, wb_we=1/wb_waddr=5/wb_wdata=32'hB -> rdata0=32'hA. Drop mem_we -> 32'hB. Drop wb_we -> rf_rdata.
- Zero register: raddr1=0, all stages write addr 0, ex_is_load=1 -> rdata1=rf_rdata1, stall_o=0.
- Load-use with LOAD_LAT=1: ex_we=1, ex_waddr=3, ex_is_load=1, raddr0=3, rd_en0=1 -> stall_o=1 for exactly 1 cycle. Next cycle (EX now bubble, mem_waddr=3) -> stall_o=0, rdata0=mem_wdata.
- Branch on load with LOAD_LAT=2: branch_flag=1, hit on port 1, ex_is_load=1 -> stall_o high for exactly 3 consecutive cycles. Branch on ALU result -> stall_o high for exactly 1 cycle.
- Flush mid-stall (LOAD_LAT=3): flush_i in the 2nd stall cycle -> stall_o=0 in that cycle; state RUN next cycle. Async rst_n_i low mid-STALL -> stall_o=0 and rdata_o=0 immediately.
- HAZARD_PERF_EN: two load-use events with LOAD_LAT=2 plus one branch-ALU stall -> stall_cycles_o=5. After reset -> 0.
